// File: rtl/risc_pkg.sv
// Shared fetch-stage types and constants for the 32-bit RISC core.
package risc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive request cycles without an acknowledge.
// expired fires in the cycle that would bring the count to TIMEOUT.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned    CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TOP  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_q, count_d;

  // next count: clear wins, otherwise count up and saturate at TIMEOUT
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != TOP)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch stage feeding the instruction holding register.
//
// state | meaning
// IDLE  | waiting for run; a request is launched directly on run=1
// FETCH | request outstanding (mem_req=1) or one-cycle gap before the next request
// ISSUE | fetched word held on instr; ir_write pulses once when not stalled
// FAULT | memory never answered; sticky until reset
//
// mem_addr is a separate register loaded when a request launches so that a
// redirect can retarget fetch_pc without disturbing the outstanding address.
module instr_fetch_unit
  import risc_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned        TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              ir_write,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] INSTR_STEP = ADDR_W'(INSTR_BYTES);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              ir_write_q, ir_write_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic              discard_q, discard_d;

  logic              timeout;
  logic [ADDR_W-1:0] redirect_target;
  logic              unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!mem_req_q || mem_ack),
    .enable  (mem_req_q),
    .expired (timeout)
  );

  // next-state, handshake and capture logic
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = 1'b0;
    ir_write_d = 1'b0;
    instr_d    = instr_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    discard_d  = discard_q;

    if (redirect && (state_q != FAULT)) begin
      fetch_pc_d = redirect_target;
    end

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d   = FETCH;
          mem_req_d = 1'b1;
        end
      end

      FETCH: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_ack) begin
          discard_d = 1'b0;
          if (!discard_q && !redirect) begin
            instr_d    = mem_rdata;
            pc_d       = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + INSTR_STEP;
            ir_write_d = !stall;
            state_d    = ISSUE;
          end
        end else if (timeout) begin
          state_d   = FAULT;
          fault_d   = 1'b1;
          discard_d = 1'b0;
        end else begin
          mem_req_d = 1'b1;
          if (redirect) begin
            discard_d = 1'b1;
          end
        end
      end

      ISSUE: begin
        // leave once the write has gone out, or squash a still-pending word
        if (ir_write_q || redirect) begin
          if (run) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end else if (!stall) begin
          ir_write_d = 1'b1;
        end
      end

      default: begin
        state_d = FAULT;
      end
    endcase

    if (mem_req_d && !mem_req_q) begin
      mem_addr_d = fetch_pc_d;
    end
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      ir_write_q <= 1'b0;
      instr_q    <= '0;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      ir_write_q <= ir_write_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      discard_q  <= discard_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ir_write = ir_write_q;
  assign instr    = instr_q;
  assign pc       = pc_q;
  assign fault    = fault_q;
  assign busy     = (state_q == FETCH) || (state_q == ISSUE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table of fetch transactions,
// directed corner sequences, then randomized traffic against a
// transaction-level model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        run;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        ir_write;
  logic [31:0] pc;
  logic        busy;
  logic        fault;

  int n_checks = 0;
  int n_err    = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .ir_write    (ir_write),
    .pc          (pc),
    .busy        (busy),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench did not terminate");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!mem_req && n < 40) begin
      tick();
      n++;
    end
    chk(name, {31'd0, mem_req}, 32'd1);
  endtask

  // One complete fetch: wait_cyc request cycles without ack, ack in the
  // next, stall held for stall_cyc cycles starting with the ack cycle.
  task automatic do_fetch(input int wait_cyc, input int stall_cyc,
                          input logic [31:0] data, input logic [31:0] exp_addr);
    wait_req("fetch_req");
    chk("fetch_addr", mem_addr, exp_addr);
    for (int w = 0; w < wait_cyc; w++) begin
      tick();
      chk("wait_req_held", {31'd0, mem_req}, 32'd1);
      chk("wait_addr_stable", mem_addr, exp_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    stall     = (stall_cyc != 0);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    for (int s = 0; s < stall_cyc; s++) begin
      chk("stall_no_write", {31'd0, ir_write}, 32'd0);
      chk("stall_no_req", {31'd0, mem_req}, 32'd0);
      chk("stall_instr_held", instr, data);
      if (s == stall_cyc - 1) stall = 1'b0;
      tick();
    end
    chk("issue_write", {31'd0, ir_write}, 32'd1);
    chk("issue_instr", instr, data);
    chk("issue_pc", pc, exp_addr);
    chk("issue_no_fault", {31'd0, fault}, 32'd0);
    tick();
    chk("issue_single_write", {31'd0, ir_write}, 32'd0);
  endtask

  task automatic no_write_until_req(input string name);
    for (int i = 0; i < 10 && !mem_req; i++) begin
      chk(name, {31'd0, ir_write}, 32'd0);
      tick();
    end
    chk(name, {31'd0, mem_req}, 32'd1);
  endtask

  typedef struct {
    int          wait_cyc;
    int          stall_cyc;
    logic [31:0] data;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[6];

  // transaction-level reference model state
  logic [31:0] nxt, req_addr, p_data, p_addr;
  logic        outst, dead, pend_v, exp_w;
  int          wait_left;
  int          n_writes;

  initial begin
    vecs[0] = '{0,  0, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{3,  0, 32'h1234_5678, 32'h0000_0004};
    vecs[2] = '{0,  4, 32'hCAFE_F00D, 32'h0000_0008};
    vecs[3] = '{2,  2, 32'h0A0B_0C0D, 32'h0000_000C};
    vecs[4] = '{15, 0, 32'h55AA_55AA, 32'h0000_0010};
    vecs[5] = '{0,  1, 32'h0123_4567, 32'h0000_0014};

    reset = 1'b0; run = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

    // reset state
    tick(); tick(); tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_ir_write", {31'd0, ir_write}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    run   = 1'b1;
    tick();
    chk("first_req", {31'd0, mem_req}, 32'd1);

    // table of back-to-back fetches
    foreach (vecs[i]) begin
      do_fetch(vecs[i].wait_cyc, vecs[i].stall_cyc, vecs[i].data, vecs[i].addr);
    end

    // redirect while waiting for ack: response dropped, refetch at target
    wait_req("rdf_req");
    chk("rdf_addr", mem_addr, 32'h18);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("rdf_addr_stable", mem_addr, 32'h18);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0;
    no_write_until_req("rdf_no_write");
    chk("rdf_target", mem_addr, 32'h100);
    do_fetch(1, 0, 32'h2222_2222, 32'h100);

    // redirect in the same cycle as ack
    wait_req("rda_req");
    chk("rda_addr", mem_addr, 32'h104);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
    tick();
    redirect = 1'b0; mem_ack = 1'b0;
    no_write_until_req("rda_no_write");
    chk("rda_target", mem_addr, 32'h200);
    do_fetch(0, 0, 32'h4444_4444, 32'h200);

    // redirect beats stall in ISSUE: held word is squashed
    wait_req("rdi_req");
    chk("rdi_addr", mem_addr, 32'h204);
    stall = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0;
    chk("rdi_held", instr, 32'h5555_5555);
    chk("rdi_pc", pc, 32'h204);
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect = 1'b0; stall = 1'b0;
    no_write_until_req("rdi_no_write");
    chk("rdi_target", mem_addr, 32'h300);

    // wrap at the top of the address space, then reset mid-request
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    do_fetch(0, 0, 32'h6666_6666, 32'hFFFF_FFFC);
    wait_req("wrap_req");
    chk("wrap_addr", mem_addr, 32'h0);
    #1 reset = 1'b0;
    #1;
    chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_instr", instr, 32'h0);
    tick();
    reset = 1'b1;

    // timeout: 16 request cycles with no ack
    wait_req("to_req");
    for (int i = 0; i < 15; i++) tick();
    chk("to_not_yet", {31'd0, fault}, 32'd0);
    chk("to_req_held", {31'd0, mem_req}, 32'd1);
    tick();
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_req_low", {31'd0, mem_req}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      mem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      chk("to_sticky", {31'd0, fault}, 32'd1);
      chk("to_sticky_req", {31'd0, mem_req}, 32'd0);
      chk("to_sticky_write", {31'd0, ir_write}, 32'd0);
    end
    mem_ack = 1'b0; redirect = 1'b0;
    reset = 1'b0;
    tick();
    chk("to_reset_clears", {31'd0, fault}, 32'd0);
    tick();
    reset = 1'b1;

    // randomized traffic against the transaction model
    nxt = 32'h0; outst = 1'b0; dead = 1'b0; pend_v = 1'b0; exp_w = 1'b0;
    req_addr = 32'h0; p_data = 32'h0; p_addr = 32'h0; wait_left = 0; n_writes = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (exp_w) begin
        chk("rnd_write", {31'd0, ir_write}, 32'd1);
        chk("rnd_instr", instr, p_data);
        chk("rnd_pc", pc, p_addr);
        pend_v = 1'b0;
        n_writes++;
      end else begin
        chk("rnd_nowrite", {31'd0, ir_write}, 32'd0);
      end
      if (outst) chk("rnd_req_hold", {31'd0, mem_req}, 32'd1);
      if (mem_req) begin
        if (!outst) begin
          chk("rnd_addr", mem_addr, nxt);
          outst = 1'b1; req_addr = nxt; dead = 1'b0;
          wait_left = int'($urandom_range(0, 4));
        end else begin
          chk("rnd_addr_stable", mem_addr, req_addr);
        end
      end
      if (pend_v) chk("rnd_no_req_pending", {31'd0, mem_req}, 32'd0);
      chk("rnd_fault", {31'd0, fault}, 32'd0);

      run         = ($urandom_range(0, 7) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      mem_ack     = 1'b0;
      mem_rdata   = $urandom;
      if (mem_req && outst) begin
        if (wait_left == 0) mem_ack = 1'b1;
        else wait_left--;
      end

      if (redirect) begin
        nxt = {redirect_pc[31:2], 2'b00};
        pend_v = 1'b0;
        if (outst) dead = 1'b1;
      end
      if (mem_ack) begin
        outst = 1'b0;
        if (!dead) begin
          pend_v = 1'b1; p_data = mem_rdata; p_addr = req_addr;
          nxt = req_addr + 32'd4;
        end
      end
      exp_w = pend_v && !stall && !redirect;
      tick();
    end
    chk("rnd_progress", {31'd0, (n_writes >= 50)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
